// File: rtl/ins_fetch.sv
// Instruction fetch unit: issues one 32-bit instruction-bus read per accepted request
// and holds the returned word (or a NOP on a fault) for the decoder.
module ins_fetch #(
    parameter int          TIMEOUT = 255,
    parameter logic [31:0] NOP_INS = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_req,
    input  logic [31:0] pc,
    input  logic        flush,
    output logic [31:0] ibus_addr,
    output logic        ibus_rd,
    input  logic        ibus_rdy,
    input  logic        ibus_err,
    input  logic [31:0] ibus_rdata,
    output logic [31:0] ins,
    output logic [31:0] ins_pc,
    output logic        ins_vld,
    output logic        ins_addr_mis,
    output logic        ins_acc_fault,
    output logic        busy
);

    localparam int              CW        = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam int              TO_LAST_I = (TIMEOUT > 0) ? (TIMEOUT - 1) : 0;
    localparam logic [CW-1:0]   TO_LAST   = CW'(TO_LAST_I);
    localparam logic [CW-1:0]   CNT_MAX   = {CW{1'b1}};
    localparam bit              TO_EN     = (TIMEOUT != 32'sd0);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUS  = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   ibus_addr_q, ibus_addr_d;
    logic          ibus_rd_q, ibus_rd_d;
    logic [31:0]   ins_q, ins_d;
    logic [31:0]   ins_pc_q, ins_pc_d;
    logic          ins_vld_q, ins_vld_d;
    logic          mis_q, mis_d;
    logic          acc_q, acc_d;
    logic          busy_q, busy_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          timeout_hit_s;

    assign timeout_hit_s = TO_EN && (cnt_q == TO_LAST);

    // Next-state and next-output computation for the IDLE/BUS controller.
    always_comb begin
        state_d     = state_q;
        ibus_addr_d = ibus_addr_q;
        ibus_rd_d   = ibus_rd_q;
        ins_d       = ins_q;
        ins_pc_d    = ins_pc_q;
        ins_vld_d   = 1'b0;
        mis_d       = mis_q;
        acc_d       = acc_q;
        busy_d      = busy_q;
        cnt_d       = cnt_q;
        case (state_q)
            IDLE: begin
                // The cycle carrying ins_vld is still owned by the previous fetch.
                if (fetch_req && !flush && !ins_vld_q) begin
                    ibus_addr_d = pc;
                    ins_pc_d    = pc;
                    mis_d       = 1'b0;
                    acc_d       = 1'b0;
                    if (pc[1:0] != 2'b00) begin
                        mis_d     = 1'b1;
                        ins_d     = NOP_INS;
                        ins_vld_d = 1'b1;
                    end else begin
                        state_d   = BUS;
                        ibus_rd_d = 1'b1;
                        busy_d    = 1'b1;
                        cnt_d     = {CW{1'b0}};
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            BUS: begin
                if (flush) begin
                    state_d   = IDLE;
                    ibus_rd_d = 1'b0;
                    busy_d    = 1'b0;
                end else if (ibus_err || ibus_rdy || timeout_hit_s) begin
                    // Error (with or without rdy) and timeout both end as access faults.
                    state_d   = IDLE;
                    ibus_rd_d = 1'b0;
                    busy_d    = 1'b0;
                    ins_vld_d = 1'b1;
                    if (ibus_err || !ibus_rdy) begin
                        acc_d = 1'b1;
                        ins_d = NOP_INS;
                    end else begin
                        ins_d = ibus_rdata;
                    end
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CW'(1);
                end else begin
                    cnt_d = cnt_q;
                end
            end
            default: begin
                state_d   = IDLE;
                ibus_rd_d = 1'b0;
                busy_d    = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ibus_addr_q <= 32'h0000_0000;
            ibus_rd_q   <= 1'b0;
            ins_q       <= NOP_INS;
            ins_pc_q    <= 32'h0000_0000;
            ins_vld_q   <= 1'b0;
            mis_q       <= 1'b0;
            acc_q       <= 1'b0;
            busy_q      <= 1'b0;
            cnt_q       <= {CW{1'b0}};
        end else begin
            state_q     <= state_d;
            ibus_addr_q <= ibus_addr_d;
            ibus_rd_q   <= ibus_rd_d;
            ins_q       <= ins_d;
            ins_pc_q    <= ins_pc_d;
            ins_vld_q   <= ins_vld_d;
            mis_q       <= mis_d;
            acc_q       <= acc_d;
            busy_q      <= busy_d;
            cnt_q       <= cnt_d;
        end
    end

    assign ibus_addr     = ibus_addr_q;
    assign ibus_rd       = ibus_rd_q;
    assign ins           = ins_q;
    assign ins_pc        = ins_pc_q;
    assign ins_vld       = ins_vld_q;
    assign ins_addr_mis  = mis_q;
    assign ins_acc_fault = acc_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_ins_fetch.sv
// Scoreboard bench for ins_fetch: the driver pushes the expected fetch outcome,
// a negedge monitor pops and compares whenever ins_vld is seen.
module tb_ins_fetch;

    localparam int          TO  = 4;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fetch_req = 1'b0;
    logic [31:0] pc = 32'h0;
    logic        flush = 1'b0;
    logic [31:0] ibus_addr;
    logic        ibus_rd;
    logic        ibus_rdy = 1'b0;
    logic        ibus_err = 1'b0;
    logic [31:0] ibus_rdata = 32'h0;
    logic [31:0] ins;
    logic [31:0] ins_pc;
    logic        ins_vld;
    logic        ins_addr_mis;
    logic        ins_acc_fault;
    logic        busy;

    ins_fetch #(.TIMEOUT(TO), .NOP_INS(NOP)) dut (
        .clk(clk), .rst_n(rst_n), .fetch_req(fetch_req), .pc(pc), .flush(flush),
        .ibus_addr(ibus_addr), .ibus_rd(ibus_rd), .ibus_rdy(ibus_rdy),
        .ibus_err(ibus_err), .ibus_rdata(ibus_rdata), .ins(ins), .ins_pc(ins_pc),
        .ins_vld(ins_vld), .ins_addr_mis(ins_addr_mis),
        .ins_acc_fault(ins_acc_fault), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] ins;
        logic [31:0] pc;
        logic        mis;
        logic        acc;
        int          cyc;
    } exp_t;

    exp_t        sb_q[$];
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    logic [31:0] model_ins = NOP;
    logic        prev_vld = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compare every ins_vld pulse against the oldest expected outcome.
    always @(negedge clk) begin
        if (rst_n && ins_vld) begin
            check("vld_width", {31'd0, prev_vld}, 32'd0);
            if (sb_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_vld: got ins_vld=1 expected no pulse (t=%0t)", $time);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("ins", ins, e.ins);
                check("ins_pc", ins_pc, e.pc);
                check("addr_mis", {31'd0, ins_addr_mis}, {31'd0, e.mis});
                check("acc_fault", {31'd0, ins_acc_fault}, {31'd0, e.acc});
                check("vld_cycle", cyc, e.cyc);
            end
        end
        prev_vld = rst_n & ins_vld;
    end

    // mode: 0 data, 1 rdy+err, 2 err alone, 3 no response (timeout)
    task automatic do_fetch(input logic [31:0] a, input int waits, input int mode,
                            input logic [31:0] data);
        exp_t e;
        int   acc;
        int   nbus;
        @(negedge clk);
        fetch_req = 1'b1;
        pc = a;
        @(posedge clk);
        #1;
        fetch_req = 1'b0;
        acc = cyc;
        e.pc = a;
        if (a[1:0] != 2'b00) begin
            e.ins = NOP; e.mis = 1'b1; e.acc = 1'b0; e.cyc = acc;
        end else if (mode == 3) begin
            e.ins = NOP; e.mis = 1'b0; e.acc = 1'b1; e.cyc = acc + TO;
        end else if (mode != 0) begin
            e.ins = NOP; e.mis = 1'b0; e.acc = 1'b1; e.cyc = acc + 1 + waits;
        end else begin
            e.ins = data; e.mis = 1'b0; e.acc = 1'b0; e.cyc = acc + 1 + waits;
        end
        sb_q.push_back(e);
        model_ins = e.ins;
        if (a[1:0] != 2'b00) begin
            @(negedge clk);
            check("mis_no_rd", {31'd0, ibus_rd}, 32'd0);
            return;
        end
        nbus = (mode == 3) ? TO : waits;
        for (int i = 0; i < nbus; i++) begin
            @(negedge clk);
            check("wait_rd", {31'd0, ibus_rd}, 32'd1);
            check("wait_addr", ibus_addr, a);
            // Requests while busy must be ignored.
            fetch_req = 1'($urandom_range(0, 1));
            pc = $urandom;
            @(posedge clk);
            #1;
        end
        fetch_req = 1'b0;
        if (mode != 3) begin
            @(negedge clk);
            check("resp_rd", {31'd0, ibus_rd}, 32'd1);
            check("resp_addr", ibus_addr, a);
            ibus_rdy = (mode != 2);
            ibus_err = (mode != 0);
            ibus_rdata = data;
            @(posedge clk);
            #1;
            ibus_rdy = 1'b0;
            ibus_err = 1'b0;
            ibus_rdata = $urandom;
        end
        @(negedge clk);
        check("done_rd", {31'd0, ibus_rd}, 32'd0);
        check("done_busy", {31'd0, busy}, 32'd0);
    endtask

    task automatic do_flush(input logic [31:0] a, input int waits);
        @(negedge clk);
        fetch_req = 1'b1;
        pc = a;
        @(posedge clk);
        #1;
        fetch_req = 1'b0;
        for (int i = 0; i < waits; i++) begin
            @(negedge clk);
            check("fl_wait_rd", {31'd0, ibus_rd}, 32'd1);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        flush = 1'b1;
        ibus_rdy = 1'b1;
        ibus_rdata = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        flush = 1'b0;
        ibus_rdy = 1'b0;
        @(negedge clk);
        check("fl_busy", {31'd0, busy}, 32'd0);
        check("fl_rd", {31'd0, ibus_rd}, 32'd0);
        check("fl_ins", ins, model_ins);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish expected finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] a;
        int          mode;
        repeat (3) @(negedge clk);
        check("rst_ins", ins, NOP);
        check("rst_vld", {31'd0, ins_vld}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_rd", {31'd0, ibus_rd}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_addr", ibus_addr, 32'h0);
        check("rst_ins_pc", ins_pc, 32'h0);
        check("rst_flags", {30'd0, ins_addr_mis, ins_acc_fault}, 32'd0);

        do_fetch(32'h0000_0100, 0, 0, 32'h0050_0093);
        do_fetch(32'h0000_0102, 0, 0, 32'h0);
        do_fetch(32'h0000_0200, 3, 1, 32'h1234_5678);
        do_fetch(32'h0000_0400, 0, 3, 32'h0);
        do_fetch(32'h0000_0500, 2, 2, 32'h0);
        do_fetch(32'h0000_0600, TO - 1, 0, 32'hCAFE_0001);
        do_flush(32'h0000_0700, 1);
        do_fetch(32'h0000_0704, 0, 0, 32'h0000_0513);

        // Flush in IDLE blocks a same-cycle request.
        @(negedge clk);
        fetch_req = 1'b1;
        flush = 1'b1;
        pc = 32'h0000_0300;
        @(posedge clk);
        #1;
        fetch_req = 1'b0;
        flush = 1'b0;
        @(negedge clk);
        check("idle_flush_busy", {31'd0, busy}, 32'd0);
        check("idle_flush_rd", {31'd0, ibus_rd}, 32'd0);

        // Asynchronous reset in the middle of a bus cycle.
        @(negedge clk);
        fetch_req = 1'b1;
        pc = 32'h0000_0800;
        @(posedge clk);
        #1;
        fetch_req = 1'b0;
        @(negedge clk);
        check("pre_rst_rd", {31'd0, ibus_rd}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_rd", {31'd0, ibus_rd}, 32'd0);
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_vld", {31'd0, ins_vld}, 32'd0);
        check("arst_ins", ins, NOP);
        check("arst_ins_pc", ins_pc, 32'h0);
        model_ins = NOP;
        @(negedge clk);
        rst_n = 1'b1;
        do_fetch(32'h0000_0900, 1, 0, 32'h00A0_0113);

        for (int n = 0; n < 40; n++) begin
            a = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
            if ($urandom_range(0, 5) == 0) a[1:0] = 2'($urandom_range(1, 3));
            mode = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            if ($urandom_range(0, 7) == 0) do_flush(a & 32'hFFFF_FFFC, $urandom_range(0, TO - 2));
            else do_fetch(a, $urandom_range(0, TO - 1), mode, $urandom);
        end

        repeat (3) @(negedge clk);
        check("sb_empty", sb_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
